// File: rtl/tdc_fifo_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : tdc_fifo_reader_if
// Brief    : FIFO read port and byte-transmitter handshake for tdc_fifo_reader.
// Revision : 1.0
// ============================================================================
interface tdc_fifo_reader_if;
   logic        fifo_empty;
   logic [31:0] fifo_dout;
   logic        fifo_rd_en;
   logic        tx_busy;
   logic [7:0]  tx_data;
   logic        tx_new_data;

   modport master (
      input  fifo_empty, fifo_dout, tx_busy,
      output fifo_rd_en, tx_data, tx_new_data
   );

   modport slave (
      output fifo_empty, fifo_dout, tx_busy,
      input  fifo_rd_en, tx_data, tx_new_data
   );
endinterface
`default_nettype wire

// File: rtl/tdc_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tdc_fifo_reader
// Brief    : Pops 32-bit TDC words and frames each as HEADER, time1, calib_diff
//            bytes. Define TDC_FRAME_CHECKSUM_EN to append an XOR checksum byte.
// Revision : 1.0
// ============================================================================
module tdc_fifo_reader #(
   parameter logic [7:0] HEADER_BYTE = 8'hA5,
   parameter int         RD_LATENCY  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   tdc_fifo_reader_if.master     bus,
   input  logic                  pause,
   output logic                  frame_active,
   output logic [15:0]           frames_sent
);
   localparam logic [2:0] c_idle      = 3'd0;
   localparam logic [2:0] c_wait_data = 3'd1;
   localparam logic [2:0] c_send      = 3'd2;
   localparam logic [2:0] c_guard     = 3'd3;
   localparam logic [2:0] c_done      = 3'd4;

   localparam logic [1:0] c_rd_lat = RD_LATENCY[1:0];
`ifdef TDC_FRAME_CHECKSUM_EN
   localparam logic [2:0] c_last_idx = 3'd5;
`else
   localparam logic [2:0] c_last_idx = 3'd4;
`endif

   logic [2:0]  r_state;
   logic [1:0]  r_lat_cnt;
   logic [2:0]  r_idx;
   logic [31:0] r_word;
   logic        r_rd_en;
   logic        r_new_data;
   logic [7:0]  r_tx_data;
   logic        r_frame_active;
   logic [15:0] r_frames_sent;
   logic [7:0]  w_byte;

`ifdef TDC_FRAME_CHECKSUM_EN
   logic [7:0]  w_checksum;
   assign w_checksum = r_word[31:24] ^ r_word[23:16] ^ r_word[15:8] ^ r_word[7:0];
`endif

   always_comb begin
      w_byte = HEADER_BYTE;
      case (r_idx)
         3'd1:    w_byte = r_word[15:8];
         3'd2:    w_byte = r_word[7:0];
         3'd3:    w_byte = r_word[31:24];
         3'd4:    w_byte = r_word[23:16];
`ifdef TDC_FRAME_CHECKSUM_EN
         3'd5:    w_byte = w_checksum;
`endif
         default: w_byte = HEADER_BYTE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= c_idle;
         r_lat_cnt      <= 2'd0;
         r_idx          <= 3'd0;
         r_word         <= 32'h0;
         r_rd_en        <= 1'b0;
         r_new_data     <= 1'b0;
         r_tx_data      <= 8'h00;
         r_frame_active <= 1'b0;
         r_frames_sent  <= 16'h0000;
      end else begin
         r_rd_en    <= 1'b0;
         r_new_data <= 1'b0;
         case (r_state)
            c_idle: begin
               if (!bus.fifo_empty && !pause) begin
                  r_rd_en        <= 1'b1;
                  r_frame_active <= 1'b1;
                  r_lat_cnt      <= 2'd0;
                  r_idx          <= 3'd0;
                  r_state        <= c_wait_data;
               end
            end
            c_wait_data: begin
               if (r_lat_cnt == c_rd_lat) begin
                  r_word <= bus.fifo_dout;
                  // Header is constant, so it can leave in the same edge the word is latched.
                  if (!bus.tx_busy) begin
                     r_tx_data  <= HEADER_BYTE;
                     r_new_data <= 1'b1;
                     r_state    <= c_guard;
                  end else begin
                     r_state <= c_send;
                  end
               end else begin
                  r_lat_cnt <= r_lat_cnt + 2'd1;
               end
            end
            c_send: begin
               if (!bus.tx_busy) begin
                  r_tx_data  <= w_byte;
                  r_new_data <= 1'b1;
                  r_state    <= c_guard;
               end
            end
            c_guard: begin
               if (r_idx == c_last_idx) begin
                  r_state <= c_done;
               end else begin
                  r_idx   <= r_idx + 3'd1;
                  r_state <= c_send;
               end
            end
            c_done: begin
               r_frames_sent  <= r_frames_sent + 16'd1;
               r_frame_active <= 1'b0;
               r_state        <= c_idle;
            end
            default: r_state <= c_idle;
         endcase
      end
   end

   assign bus.fifo_rd_en  = r_rd_en;
   assign bus.tx_new_data = r_new_data;
   assign bus.tx_data     = r_tx_data;
   assign frame_active    = r_frame_active;
   assign frames_sent     = r_frames_sent;
endmodule
`default_nettype wire

// File: tb/tb_tdc_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdc_fifo_reader
// Brief    : Self-checking bench; instance 0 uses RD_LATENCY=1, instance 1 uses 2.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_tdc_fifo_reader;
   localparam logic [7:0] HDR = 8'hA5;
`ifdef TDC_FRAME_CHECKSUM_EN
   localparam int FRAME_LEN = 6;
`else
   localparam int FRAME_LEN = 5;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pause = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   busy_hold = 0;
   logic [31:0] fmem [2][16];
   int   fwr [2] = '{0, 0};
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      tdc_fifo_reader_if bus ();
      logic        frame_active;
      logic [15:0] frames_sent;
      int          frd = 0;
      logic [31:0] d1 = 32'h0, d2 = 32'h0;
      logic        v1 = 1'b0, v2 = 1'b0;
      int          bcnt = 0, cyc = 0, last = -10;
      logic [7:0]  cap [256];
      int          ncap = 0, npop = 0, viol_pop = 0, viol_tx = 0;
      logic        prev_fa = 1'b0;

      tdc_fifo_reader #(.HEADER_BYTE(HDR), .RD_LATENCY(g + 1)) u_dut (
         .clk(clk), .rst(rst), .bus(bus), .pause(pause),
         .frame_active(frame_active), .frames_sent(frames_sent)
      );

      // FIFO read port: data shows only in its valid cycle, junk otherwise
      assign bus.fifo_empty = (fwr[g] == frd);
      assign bus.fifo_dout  = (g == 0) ? (v1 ? d1 : 32'hDEAD_BEEF) : (v2 ? d2 : 32'hDEAD_BEEF);
      assign bus.tx_busy    = (bcnt != 0);

      always @(posedge clk) begin
         v1 <= 1'b0;
         if (bus.fifo_rd_en && (fwr[g] != frd)) begin
            d1  <= fmem[g][frd % 16];
            v1  <= 1'b1;
            frd <= frd + 1;
         end
         v2 <= v1;
         d2 <= d1;
         if (bus.tx_new_data) bcnt <= busy_hold;
         else if (bcnt > 0)   bcnt <= bcnt - 1;
         cyc <= cyc + 1;
      end

      always @(negedge clk) begin
         prev_fa <= frame_active;
         if (bus.fifo_rd_en) begin
            npop <= npop + 1;
            if (prev_fa) viol_pop <= viol_pop + 1;
         end
         if (bus.tx_new_data) begin
            cap[ncap % 256] <= bus.tx_data;
            ncap <= ncap + 1;
            last <= cyc;
            if (bus.tx_busy || (cyc - last < 2)) viol_tx <= viol_tx + 1;
         end
      end
   end

   function automatic void add_frame(input logic [31:0] w);
      exp_q.push_back(HDR);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
`ifdef TDC_FRAME_CHECKSUM_EN
      exp_q.push_back(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
   endfunction

   function automatic int get_ncap(input int g);
      return (g == 0) ? g_inst[0].ncap : g_inst[1].ncap;
   endfunction
   function automatic logic [7:0] get_cap(input int g, input int i);
      return (g == 0) ? g_inst[0].cap[i % 256] : g_inst[1].cap[i % 256];
   endfunction
   function automatic logic [15:0] get_frames(input int g);
      return (g == 0) ? g_inst[0].frames_sent : g_inst[1].frames_sent;
   endfunction

   task automatic push(input int g, input logic [31:0] w);
      fmem[g][fwr[g] % 16] = w;
      fwr[g] = fwr[g] + 1;
   endtask

   task automatic wait_cap(input int g, input int n, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (get_ncap(g) >= n) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic wait_frames(input int g, input logic [15:0] target, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (get_frames(g) == target) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++; if (((g == 0) ? g_inst[0].bus.fifo_rd_en : g_inst[1].bus.fifo_rd_en) !== 1'b0) begin errors++; $display("FAIL reset_rd_en[%0d]: got 1 expected 0", g); end
         checks++; if (((g == 0) ? g_inst[0].bus.tx_new_data : g_inst[1].bus.tx_new_data) !== 1'b0) begin errors++; $display("FAIL reset_new_data[%0d]: got 1 expected 0", g); end
         checks++; if (((g == 0) ? g_inst[0].bus.tx_data : g_inst[1].bus.tx_data) !== 8'h00) begin errors++; $display("FAIL reset_tx_data[%0d]: nonzero expected 00", g); end
         checks++; if (((g == 0) ? g_inst[0].frame_active : g_inst[1].frame_active) !== 1'b0) begin errors++; $display("FAIL reset_frame_active[%0d]: got 1 expected 0", g); end
         checks++; if (get_frames(g) !== 16'h0000) begin errors++; $display("FAIL reset_frames_sent[%0d]: got %h expected 0000", g, get_frames(g)); end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_word;
      int s, p0, t; bit ok;
      busy_hold = 3; exp_q.delete(); add_frame(32'h1234_0190);
      s = g_inst[0].ncap; p0 = g_inst[0].npop;
      push(0, 32'h1234_0190);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin @(negedge clk); ok = g_inst[0].bus.fifo_rd_en; end
      t = 0;
      while (!g_inst[0].bus.tx_new_data && t < 50) begin @(negedge clk); t++; end
      checks++; if (t !== 2) begin errors++; $display("FAIL single_latency: got %0d cycles expected 2", t); end
      wait_frames(0, 16'd1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_timeout: frames_sent %h expected 0001", get_frames(0)); end
      for (int i = 0; i < FRAME_LEN; i++) begin
         checks++; if (get_cap(0, s + i) !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d: got %h expected %h", i, get_cap(0, s + i), exp_q[i]); end
      end
      checks++; if (g_inst[0].npop - p0 !== 1) begin errors++; $display("FAIL single_pops: got %0d expected 1", g_inst[0].npop - p0); end
      checks++; if (g_inst[0].frames_sent !== 16'd1) begin errors++; $display("FAIL single_frames: got %h expected 0001", g_inst[0].frames_sent); end
   endtask

   task automatic test_back_to_back;
      int s, p0; bit ok; logic [31:0] w; logic [15:0] f0;
      busy_hold = 0; exp_q.delete();
      s = g_inst[0].ncap; p0 = g_inst[0].npop; f0 = g_inst[0].frames_sent;
      for (int k = 0; k < 3; k++) begin w = $urandom; add_frame(w); push(0, w); end
      wait_frames(0, f0 + 16'd3, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: frames_sent %h expected %h", g_inst[0].frames_sent, f0 + 16'd3); end
      for (int i = 0; i < 3 * FRAME_LEN; i++) begin
         checks++; if (get_cap(0, s + i) !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, get_cap(0, s + i), exp_q[i]); end
      end
      checks++; if (g_inst[0].npop - p0 !== 3) begin errors++; $display("FAIL b2b_pops: got %0d expected 3", g_inst[0].npop - p0); end
      checks++; if (g_inst[0].viol_tx !== 0) begin errors++; $display("FAIL b2b_tx_spacing: got %0d violations expected 0", g_inst[0].viol_tx); end
      checks++; if (g_inst[0].viol_pop !== 0) begin errors++; $display("FAIL b2b_pop_while_active: got %0d expected 0", g_inst[0].viol_pop); end
   endtask

   task automatic test_pause;
      int s, p0; bit ok; logic [31:0] w1, w2, w3; logic [15:0] f0;
      busy_hold = 2; exp_q.delete();
      s = g_inst[0].ncap; p0 = g_inst[0].npop; f0 = g_inst[0].frames_sent;
      w1 = $urandom; w2 = $urandom; w3 = $urandom;
      add_frame(w1); add_frame(w2); add_frame(w3);
      push(0, w1); push(0, w2);
      wait_cap(0, s + 2, ok);
      pause = 1'b1;
      wait_frames(0, f0 + 16'd1, ok);
      repeat (20) @(negedge clk);
      checks++; if (g_inst[0].npop - p0 !== 1) begin errors++; $display("FAIL pause_pops: got %0d expected 1", g_inst[0].npop - p0); end
      checks++; if (g_inst[0].ncap - s !== FRAME_LEN) begin errors++; $display("FAIL pause_bytes: got %0d expected %0d", g_inst[0].ncap - s, FRAME_LEN); end
      pause = 1'b0;
      wait_frames(0, f0 + 16'd2, ok);
      checks++; if (g_inst[0].npop - p0 !== 2) begin errors++; $display("FAIL pause_resume_pops: got %0d expected 2", g_inst[0].npop - p0); end
      // pause and fifo_empty falling in the same cycle: no pop
      pause = 1'b1; push(0, w3);
      repeat (10) @(negedge clk);
      checks++; if (g_inst[0].npop - p0 !== 2) begin errors++; $display("FAIL pause_same_cycle_pops: got %0d expected 2", g_inst[0].npop - p0); end
      pause = 1'b0;
      wait_frames(0, f0 + 16'd3, ok);
      checks++; if (!ok) begin errors++; $display("FAIL pause_timeout: frames_sent %h expected %h", g_inst[0].frames_sent, f0 + 16'd3); end
      for (int i = 0; i < 3 * FRAME_LEN; i++) begin
         checks++; if (get_cap(0, s + i) !== exp_q[i]) begin errors++; $display("FAIL pause_byte%0d: got %h expected %h", i, get_cap(0, s + i), exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid_frame;
      int s; bit ok; logic [31:0] w1, w2;
      busy_hold = 1; exp_q.delete();
      w1 = $urandom; w2 = $urandom; add_frame(w2);
      s = g_inst[0].ncap;
      push(0, w1); push(0, w2);
      wait_cap(0, s + 3, ok);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (g_inst[0].bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL midrst_rd_en: got 1 expected 0"); end
      checks++; if (g_inst[0].bus.tx_new_data !== 1'b0) begin errors++; $display("FAIL midrst_new_data: got 1 expected 0"); end
      checks++; if (g_inst[0].bus.tx_data !== 8'h00) begin errors++; $display("FAIL midrst_tx_data: got %h expected 00", g_inst[0].bus.tx_data); end
      checks++; if (g_inst[0].frame_active !== 1'b0) begin errors++; $display("FAIL midrst_frame_active: got 1 expected 0"); end
      checks++; if (g_inst[0].frames_sent !== 16'h0000) begin errors++; $display("FAIL midrst_frames: got %h expected 0000", g_inst[0].frames_sent); end
      rst = 1'b0;
      s = g_inst[0].ncap;
      wait_frames(0, 16'd1, ok);
      checks++; if (g_inst[0].ncap - s !== FRAME_LEN) begin errors++; $display("FAIL midrst_len: got %0d expected %0d", g_inst[0].ncap - s, FRAME_LEN); end
      for (int i = 0; i < FRAME_LEN; i++) begin
         checks++; if (get_cap(0, s + i) !== exp_q[i]) begin errors++; $display("FAIL midrst_byte%0d: got %h expected %h", i, get_cap(0, s + i), exp_q[i]); end
      end
   endtask

   task automatic test_wrap;
      int s; bit ok; logic [31:0] w;
      busy_hold = 0; exp_q.delete(); w = $urandom; add_frame(w);
      force g_inst[0].u_dut.r_frames_sent = 16'hFFFF;
      @(negedge clk);
      release g_inst[0].u_dut.r_frames_sent;
      @(negedge clk);
      checks++; if (g_inst[0].frames_sent !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset: got %h expected ffff", g_inst[0].frames_sent); end
      s = g_inst[0].ncap;
      push(0, w);
      wait_frames(0, 16'h0000, ok);
      checks++; if (g_inst[0].frames_sent !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %h expected 0000", g_inst[0].frames_sent); end
      for (int i = 0; i < FRAME_LEN; i++) begin
         checks++; if (get_cap(0, s + i) !== exp_q[i]) begin errors++; $display("FAIL wrap_byte%0d: got %h expected %h", i, get_cap(0, s + i), exp_q[i]); end
      end
   endtask

   task automatic test_latency2;
      int s, t; bit ok; logic [31:0] w; logic [15:0] f0;
      busy_hold = 2; exp_q.delete(); w = $urandom;
      add_frame(32'hFFFF_0000); add_frame(w);
      s = g_inst[1].ncap; f0 = g_inst[1].frames_sent;
      push(1, 32'hFFFF_0000); push(1, w);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin @(negedge clk); ok = g_inst[1].bus.fifo_rd_en; end
      t = 0;
      while (!g_inst[1].bus.tx_new_data && t < 50) begin @(negedge clk); t++; end
      checks++; if (t !== 3) begin errors++; $display("FAIL lat2_latency: got %0d cycles expected 3", t); end
      wait_frames(1, f0 + 16'd2, ok);
      checks++; if (!ok) begin errors++; $display("FAIL lat2_timeout: frames_sent %h expected %h", g_inst[1].frames_sent, f0 + 16'd2); end
      for (int i = 0; i < 2 * FRAME_LEN; i++) begin
         checks++; if (get_cap(1, s + i) !== exp_q[i]) begin errors++; $display("FAIL lat2_byte%0d: got %h expected %h", i, get_cap(1, s + i), exp_q[i]); end
      end
      checks++; if (g_inst[1].viol_tx + g_inst[1].viol_pop !== 0) begin errors++; $display("FAIL lat2_protocol: got %0d violations expected 0", g_inst[1].viol_tx + g_inst[1].viol_pop); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_pause();
      test_reset_mid_frame();
      test_wrap();
      test_latency2();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
